// File: rtl/vpu_dst_port.sv
// vpu_dst_port: destination stage behind the add/sub ALU.
// Buffers accepted results in a small FIFO and drains them to the SRAM write
// port at sequential addresses starting from a latched base. It pulses done_o
// once the latched element count has been written.
// Optional build macro VPU_DST_PORT_PERF_EN adds stall_cnt_o, a saturating
// count of cycles where a write was offered but not accepted.
module vpu_dst_port #(
    parameter int OPERAND_WIDTH = 32,
    parameter int ADDR_WIDTH    = 10,
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [ADDR_WIDTH-1:0]    base_addr_i,
    input  logic [CNT_WIDTH-1:0]     elem_cnt_i,
    input  logic [OPERAND_WIDTH-1:0] result_i,
    input  logic                     result_valid_i,
    output logic                     result_ready_o,
    output logic                     wr_en_o,
    output logic [ADDR_WIDTH-1:0]    wr_addr_o,
    output logic [OPERAND_WIDTH-1:0] wr_data_o,
    input  logic                     wr_ready_i,
    output logic                     busy_o,
    output logic                     done_o
`ifdef VPU_DST_PORT_PERF_EN
    ,
    output logic [31:0]              stall_cnt_o
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [OPERAND_WIDTH-1:0] mem_q [FIFO_DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PTR_W:0]           wptr_q, wptr_d;
    logic [PTR_W:0]           rptr_q, rptr_d;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]     acc_q, acc_d;
    logic [CNT_WIDTH-1:0]     wcnt_q, wcnt_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;

    // FIFO status and handshake outputs, all derived from registered state.
    always_comb begin
        fifo_empty     = (wptr_q == rptr_q);
        fifo_full      = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                         (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
        result_ready_o = (state_q == S_RUN) && !fifo_full && (acc_q < cnt_q);
        wr_en_o        = ((state_q == S_RUN) || (state_q == S_DRAIN)) && !fifo_empty;
        // Data is forced to zero while no write is offered so every output is
        // zero out of reset.
        wr_data_o      = wr_en_o ? mem_q[rptr_q[PTR_W-1:0]] : '0;
        wr_addr_o      = addr_q;
        busy_o         = (state_q != S_IDLE);
        done_o         = (state_q == S_DONE);
        push           = result_valid_i && result_ready_o;
        pop            = wr_en_o && wr_ready_i;
    end

    // Next-state logic for the control FSM, counters, pointers and address.
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    cnt_d   = elem_cnt_i;
                    addr_d  = base_addr_i;
                    acc_d   = '0;
                    wcnt_d  = '0;
                    wptr_d  = '0;
                    rptr_d  = '0;
                    state_d = (elem_cnt_i == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN, S_DRAIN: begin
                if (push) begin
                    wptr_d = wptr_q + 1'b1;
                    acc_d  = acc_q + 1'b1;
                end
                if (pop) begin
                    rptr_d = rptr_q + 1'b1;
                    wcnt_d = wcnt_q + 1'b1;
                    addr_d = addr_q + 1'b1;
                end
                // Transitions look at next-cycle counts so DRAIN starts right
                // after the last accept and DONE right after the last write.
                if ((state_q == S_RUN) && (acc_d == cnt_q)) begin
                    state_d = S_DRAIN;
                end
                if ((state_q == S_DRAIN) && (wcnt_d == cnt_q)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            wcnt_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
        end
    end

    // FIFO storage; contents are don't-care until a push, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[PTR_W-1:0]] <= result_i;
        end
    end

`ifdef VPU_DST_PORT_PERF_EN
    logic [31:0] stall_q, stall_d;

    // Saturating stall counter, cleared by an accepted start, held in IDLE.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == S_IDLE) && start_i) begin
            stall_d = '0;
        end else if (wr_en_o && !wr_ready_i && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_vpu_dst_port.sv
// Self-checking bench for vpu_dst_port: a cycle table for a basic run,
// hand-written corner sequences and randomized runs, all compared against a
// queue-based reference model of the destination port.
module tb_vpu_dst_port;

    localparam int OW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 4;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic [CW-1:0] elem_cnt_i;
    logic [OW-1:0] result_i;
    logic          result_valid_i;
    logic          result_ready_o;
    logic          wr_en_o;
    logic [AW-1:0] wr_addr_o;
    logic [OW-1:0] wr_data_o;
    logic          wr_ready_i;
    logic          busy_o;
    logic          done_o;
`ifdef VPU_DST_PORT_PERF_EN
    logic [31:0]   stall_cnt_o;
`endif

    always #5 clk = ~clk;

    vpu_dst_port #(
        .OPERAND_WIDTH(OW),
        .ADDR_WIDTH   (AW),
        .FIFO_DEPTH   (DEPTH),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .base_addr_i   (base_addr_i),
        .elem_cnt_i    (elem_cnt_i),
        .result_i      (result_i),
        .result_valid_i(result_valid_i),
        .result_ready_o(result_ready_o),
        .wr_en_o       (wr_en_o),
        .wr_addr_o     (wr_addr_o),
        .wr_data_o     (wr_data_o),
        .wr_ready_i    (wr_ready_i),
        .busy_o        (busy_o),
        .done_o        (done_o)
`ifdef VPU_DST_PORT_PERF_EN
        ,
        .stall_cnt_o   (stall_cnt_o)
`endif
    );

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    // Reference model: pending results, counts of accepted and written
    // elements, next write address and whether a run or completion is active.
    logic [OW-1:0] mq[$];
    bit            m_run;
    bit            m_done;
    int unsigned   m_acc, m_wr, m_cnt;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_stall;

    // Observations accumulated by step() for the hand-written sequences.
    int unsigned   n_acc, n_busy, n_done, n_wren, n_stall;
    logic [AW-1:0] seen_addr[$];

    function automatic bit m_ready();
        return m_run && (m_acc < m_cnt) && (mq.size() < DEPTH);
    endfunction

    function automatic bit m_wren();
        return m_run && (mq.size() > 0);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_run   = 1'b0;
        m_done  = 1'b0;
        m_acc   = 0;
        m_wr    = 0;
        m_cnt   = 0;
        m_addr  = '0;
        m_stall = '0;
    endtask

    // Advance the model across one rising edge using the driven inputs.
    task automatic model_update();
        bit push;
        bit pop;
        push = m_ready() && result_valid_i;
        pop  = m_wren() && wr_ready_i;
        if (m_wren() && !wr_ready_i && (m_stall != 32'hFFFF_FFFF)) m_stall++;
        if (m_done) begin
            m_done = 1'b0;
        end else if (m_run) begin
            if (pop) begin
                void'(mq.pop_front());
                m_wr++;
                m_addr++;
            end
            if (push) begin
                mq.push_back(result_i);
                m_acc++;
            end
            if (m_wr == m_cnt) begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end
        end else if (start_i) begin
            m_cnt   = 32'(elem_cnt_i);
            m_addr  = base_addr_i;
            m_acc   = 0;
            m_wr    = 0;
            m_stall = '0;
            if (m_cnt == 0) m_done = 1'b1;
            else            m_run  = 1'b1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        vectors++;
        errors++;
        $display("FAIL %s: bound expired, got busy expected idle at %0t", name, $time);
    endtask

    task automatic clear_obs();
        n_acc   = 0;
        n_busy  = 0;
        n_done  = 0;
        n_wren  = 0;
        n_stall = 0;
        seen_addr.delete();
    endtask

    // One clock cycle: compare at the falling edge, then advance the model.
    task automatic step();
        @(negedge clk);
        check("ready", 32'(result_ready_o), 32'(m_ready()));
        check("wr_en", 32'(wr_en_o), 32'(m_wren()));
        if (m_wren()) begin
            check("wr_addr", 32'(wr_addr_o), 32'(m_addr));
            check("wr_data", wr_data_o, mq[0]);
        end
        check("busy", 32'(busy_o), 32'(m_run || m_done));
        check("done", 32'(done_o), 32'(m_done));
`ifdef VPU_DST_PORT_PERF_EN
        check("stall_cnt", stall_cnt_o, m_stall);
`endif
        if (result_ready_o && result_valid_i) n_acc++;
        if (busy_o) n_busy++;
        if (done_o) n_done++;
        if (wr_en_o) n_wren++;
        if (wr_en_o && !wr_ready_i) n_stall++;
        if (wr_en_o && wr_ready_i) seen_addr.push_back(wr_addr_o);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic start_run(input logic [AW-1:0] base, input logic [CW-1:0] cnt);
        start_i     = 1'b1;
        base_addr_i = base;
        elem_cnt_i  = cnt;
        step();
        start_i     = 1'b0;
    endtask

    task automatic run_to_idle(input string name, input bit vld, input bit rdy);
        for (int c = 0; c < 300 && (m_run || m_done); c++) begin
            result_valid_i = vld;
            wr_ready_i     = rdy;
            result_i       = $urandom;
            step();
        end
        if (m_run || m_done) note_fail(name);
    endtask

    typedef struct {
        logic          start;
        logic [AW-1:0] base;
        logic [CW-1:0] cnt;
        logic          valid;
        logic [OW-1:0] data;
        logic          wrdy;
        logic          e_ready;
        logic          e_wren;
        logic [AW-1:0] e_addr;
        logic [OW-1:0] e_data;
        logic          e_busy;
        logic          e_done;
    } vec_t;

    vec_t tbl[8];

    initial begin
        // Basic run: base 0x010, four results, write side always ready.
        tbl[0] = '{1'b1, 10'h010, 16'd4, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 10'h000, 32'h0000_0000, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 10'h000, 16'd0, 1'b1, 32'h0000_0005, 1'b1, 1'b1, 1'b0, 10'h010, 32'h0000_0000, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 10'h000, 16'd0, 1'b1, 32'hFFFF_FFFD, 1'b1, 1'b1, 1'b1, 10'h010, 32'h0000_0005, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 10'h000, 16'd0, 1'b1, 32'h0000_0007, 1'b1, 1'b1, 1'b1, 10'h011, 32'hFFFF_FFFD, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 10'h000, 16'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 10'h012, 32'h0000_0007, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 10'h000, 16'd0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 10'h013, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 10'h000, 16'd0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 10'h014, 32'h0000_0000, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 10'h000, 16'd0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 10'h014, 32'h0000_0000, 1'b0, 1'b0};

        rst            = 1'b1;
        start_i        = 1'b0;
        base_addr_i    = '0;
        elem_cnt_i     = '0;
        result_i       = '0;
        result_valid_i = 1'b0;
        wr_ready_i     = 1'b0;
        model_reset();
        clear_obs();

        // Reset state.
        #1;
        check("rst_ready", 32'(result_ready_o), 32'd0);
        check("rst_wr_en", 32'(wr_en_o), 32'd0);
        check("rst_addr", 32'(wr_addr_o), 32'd0);
        check("rst_data", wr_data_o, 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Table-driven basic run.
        for (int i = 0; i < 8; i++) begin
            start_i        = tbl[i].start;
            base_addr_i    = tbl[i].base;
            elem_cnt_i     = tbl[i].cnt;
            result_valid_i = tbl[i].valid;
            result_i       = tbl[i].data;
            wr_ready_i     = tbl[i].wrdy;
            @(negedge clk);
            check($sformatf("tbl%0d_ready", i), 32'(result_ready_o), 32'(tbl[i].e_ready));
            check($sformatf("tbl%0d_wr_en", i), 32'(wr_en_o), 32'(tbl[i].e_wren));
            check($sformatf("tbl%0d_addr", i), 32'(wr_addr_o), 32'(tbl[i].e_addr));
            if (tbl[i].e_wren) check($sformatf("tbl%0d_data", i), wr_data_o, tbl[i].e_data);
            check($sformatf("tbl%0d_busy", i), 32'(busy_o), 32'(tbl[i].e_busy));
            check($sformatf("tbl%0d_done", i), 32'(done_o), 32'(tbl[i].e_done));
            @(posedge clk);
            model_update();
            #1;
        end
        start_i = 1'b0;

        // Backpressure: FIFO fills after four accepts while writes stall.
        clear_obs();
        result_valid_i = 1'b1;
        wr_ready_i     = 1'b0;
        result_i       = 32'hA000_0000;
        start_run(10'h100, 16'd8);
        for (int c = 0; c < 10; c++) begin
            result_i = 32'hA000_0000 + 32'(m_acc);
            step();
        end
        check("bp_accepts_while_stalled", n_acc, 32'd4);
        check("bp_stalled_cycles", n_stall, 32'd9);
        for (int c = 0; c < 300 && (m_run || m_done); c++) begin
            result_valid_i = (m_acc < m_cnt);
            result_i       = 32'hA000_0000 + 32'(m_acc);
            wr_ready_i     = 1'b1;
            step();
        end
        if (m_run || m_done) note_fail("bp_timeout");
        check("bp_writes", seen_addr.size(), 32'd8);
        check("bp_done_pulses", n_done, 32'd1);

        // Address wrap past the top of the SRAM.
        clear_obs();
        result_valid_i = 1'b1;
        wr_ready_i     = 1'b1;
        start_run(10'h3FE, 16'd4);
        run_to_idle("wrap_timeout", 1'b1, 1'b1);
        check("wrap_writes", seen_addr.size(), 32'd4);
        if (seen_addr.size() == 4) begin
            check("wrap_a0", 32'(seen_addr[0]), 32'h3FE);
            check("wrap_a1", 32'(seen_addr[1]), 32'h3FF);
            check("wrap_a2", 32'(seen_addr[2]), 32'h000);
            check("wrap_a3", 32'(seen_addr[3]), 32'h001);
        end

        // Zero count: one busy cycle, a done pulse, no writes.
        clear_obs();
        start_run(10'h055, 16'd0);
        run_to_idle("zero_timeout", 1'b1, 1'b1);
        step();
        check("zero_busy_cycles", n_busy, 32'd1);
        check("zero_done_pulses", n_done, 32'd1);
        check("zero_wr_en_cycles", n_wren, 32'd0);

        // Reset mid-run after three accepts, then a fresh short run.
        clear_obs();
        result_valid_i = 1'b1;
        wr_ready_i     = 1'b0;
        start_run(10'h040, 16'd6);
        for (int c = 0; c < 50 && n_acc < 3; c++) begin
            result_i = $urandom;
            step();
        end
        check("mid_accepts", n_acc, 32'd3);
        rst = 1'b1;
        #1;
        model_reset();
        check("mid_rst_ready", 32'(result_ready_o), 32'd0);
        check("mid_rst_wr_en", 32'(wr_en_o), 32'd0);
        check("mid_rst_addr", 32'(wr_addr_o), 32'd0);
        check("mid_rst_data", wr_data_o, 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_done", 32'(done_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_obs();
        start_run(10'h200, 16'd2);
        run_to_idle("mid_rerun_timeout", 1'b1, 1'b1);
        check("mid_rerun_writes", seen_addr.size(), 32'd2);
        if (seen_addr.size() == 2) begin
            check("mid_rerun_a0", 32'(seen_addr[0]), 32'h200);
            check("mid_rerun_a1", 32'(seen_addr[1]), 32'h201);
        end

`ifdef VPU_DST_PORT_PERF_EN
        // Five stalled write cycles, counter read back after completion.
        clear_obs();
        result_valid_i = 1'b1;
        wr_ready_i     = 1'b0;
        start_run(10'h000, 16'd2);
        for (int c = 0; c < 100 && (m_run || m_done); c++) begin
            result_valid_i = (m_acc < m_cnt);
            wr_ready_i     = (n_stall >= 5);
            result_i       = $urandom;
            step();
        end
        if (m_run || m_done) note_fail("perf_timeout");
        check("perf_stall_cnt", stall_cnt_o, 32'd5);
`endif

        // Randomized runs, including ignored starts while busy.
        for (int r = 0; r < 40; r++) begin
            result_valid_i = ($urandom_range(0, 3) != 0);
            wr_ready_i     = ($urandom_range(0, 2) != 0);
            result_i       = $urandom;
            start_run(AW'($urandom), CW'($urandom_range(0, 12)));
            for (int c = 0; c < 400 && (m_run || m_done); c++) begin
                start_i        = ($urandom_range(0, 7) == 0);
                base_addr_i    = AW'($urandom);
                elem_cnt_i     = CW'($urandom_range(0, 12));
                result_valid_i = ($urandom_range(0, 3) != 0);
                wr_ready_i     = ($urandom_range(0, 2) != 0);
                result_i       = $urandom;
                step();
            end
            start_i = 1'b0;
            if (m_run || m_done) note_fail("rand_timeout");
            if ($urandom_range(0, 3) == 0) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
